// File: rtl/sercmp_pkg.sv
// Shared types for the serial-compare feeder.
//   state_e : feeder FSM states (IDLE, CLEAR, SHIFT, DONE)
//   res_t   : packed comparison verdict {less, eq, greater}
//   sercmp_cnt_w : bit-counter width, never below one bit
//   sercmp_onehot3 : true when exactly one verdict bit is set
package sercmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } res_t;

  function automatic int sercmp_cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

  function automatic logic sercmp_onehot3(input res_t r);
    return (r == 3'b100) || (r == 3'b010) || (r == 3'b001);
  endfunction

endpackage

// File: rtl/serial_compare_feeder_msb_first_if.sv
// Bundle of the feeder's handshake and serial buses.
//   in_*  : parallel word-pair input handshake
//   ser_* : serial bit stream towards the comparator
//   cmp_* : comparator verdict coming back
//   res_* : captured verdict output handshake
// Modport slave is the feeder side, master is the surrounding datapath.
interface serial_compare_feeder_msb_first_if #(parameter int W = 8);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         ser_clear;
  logic         ser_a;
  logic         ser_b;
  logic         ser_valid;
  logic         ser_last;
  logic         cmp_less;
  logic         cmp_eq;
  logic         cmp_greater;
  logic         res_valid;
  logic         res_ready;
  logic         res_less;
  logic         res_eq;
  logic         res_greater;
  logic         res_mismatch;

  modport slave (
    input  in_valid, in_a, in_b, cmp_less, cmp_eq, cmp_greater, res_ready,
    output in_ready, ser_clear, ser_a, ser_b, ser_valid, ser_last,
           res_valid, res_less, res_eq, res_greater, res_mismatch
  );

  modport master (
    output in_valid, in_a, in_b, cmp_less, cmp_eq, cmp_greater, res_ready,
    input  in_ready, ser_clear, ser_a, ser_b, ser_valid, ser_last,
           res_valid, res_less, res_eq, res_greater, res_mismatch
  );
endinterface

// File: rtl/sercmp_piso.sv
// Parallel-in serial-out shift register, MSB first.
//   clk, rst : clock, synchronous active-high reset (clears the register)
//   load     : capture din (has priority over shift)
//   shift    : shift left by one, zero fill
//   din      : W-bit parallel word
//   msb      : current most significant bit (registered)
module sercmp_piso #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] sr;

  // Cleared on reset so the serial outputs idle at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[W-1];

endmodule

// File: rtl/serial_compare_feeder_msb_first.sv
// Front-end controller for the MSB-first serial comparator.
// Accepts an operand pair, pulses ser_clear for one cycle, streams both
// operands MSB first, captures the comparator verdict on the last bit and
// offers it on the res_* handshake.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport carrying in_*, ser_*, cmp_* and res_* signals
// Optional macro SERCMP_FEEDER_SELFCHECK_EN adds a parallel comparator whose
// verdict is checked against the serial one (res_mismatch); without it
// res_mismatch is constant 0.
module serial_compare_feeder_msb_first
  import sercmp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst,
  serial_compare_feeder_msb_first_if.slave bus
);

  localparam int CNT_W = sercmp_cnt_w(W);

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             ser_clear_r;
  logic             ser_valid_r;
  logic             ser_last_r;
  res_t             res_r;
  res_t             cmp_now;
  logic             accept;
  logic             capture;

  assign accept  = (state == IDLE) && bus.in_valid;
  assign capture = (state == SHIFT) && ser_last_r;
  assign cmp_now = {bus.cmp_less, bus.cmp_eq, bus.cmp_greater};

  sercmp_piso #(.W(W)) u_piso_a (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state == SHIFT),
    .din   (bus.in_a),
    .msb   (bus.ser_a)
  );

  sercmp_piso #(.W(W)) u_piso_b (
    .clk   (clk),
    .rst   (rst),
    .load  (accept),
    .shift (state == SHIFT),
    .din   (bus.in_b),
    .msb   (bus.ser_b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      ser_clear_r <= 1'b0;
      ser_valid_r <= 1'b0;
      ser_last_r  <= 1'b0;
      res_r       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            ser_clear_r <= 1'b1;
            state       <= CLEAR;
          end
        end
        CLEAR: begin
          ser_clear_r <= 1'b0;
          ser_valid_r <= 1'b1;
          cnt         <= CNT_W'(W - 1);
          ser_last_r  <= (W == 1);
          state       <= SHIFT;
        end
        SHIFT: begin
          if (ser_last_r) begin
            ser_valid_r <= 1'b0;
            ser_last_r  <= 1'b0;
            res_r       <= cmp_now;
            state       <= DONE;
          end else begin
            // ser_last is registered, so it is raised one step early.
            cnt        <= cnt - 1'b1;
            ser_last_r <= (cnt == CNT_W'(1));
          end
        end
        DONE: begin
          if (bus.res_ready) begin
            res_r <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERCMP_FEEDER_SELFCHECK_EN
  res_t par_r;
  logic mism_r;

  // Parallel reference verdict, taken with the operands.
  always_ff @(posedge clk) begin
    if (accept) begin
      par_r <= {bus.in_a < bus.in_b, bus.in_a == bus.in_b, bus.in_a > bus.in_b};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mism_r <= 1'b0;
    end else if (capture) begin
      mism_r <= (cmp_now != par_r) || !sercmp_onehot3(cmp_now);
    end else if ((state == DONE) && bus.res_ready) begin
      mism_r <= 1'b0;
    end
  end

  assign bus.res_mismatch = mism_r;
`else
  assign bus.res_mismatch = 1'b0;
`endif

  assign bus.in_ready    = (state == IDLE) && !rst;
  assign bus.res_valid   = (state == DONE);
  assign bus.ser_clear   = ser_clear_r;
  assign bus.ser_valid   = ser_valid_r;
  assign bus.ser_last    = ser_last_r;
  assign bus.res_less    = res_r.less;
  assign bus.res_eq      = res_r.eq;
  assign bus.res_greater = res_r.greater;

endmodule

// File: tb/tb_serial_compare_feeder_msb_first.sv
// Bench for serial_compare_feeder_msb_first: a W=8 instance driven by a
// behavioural MSB-first comparator, and a W=1 instance whose comparator is
// stuck at "less" to exercise the optional self-check output.
module tb_serial_compare_feeder_msb_first;
  localparam int W = 8;

`ifdef SERCMP_FEEDER_SELFCHECK_EN
  localparam logic EXP_MIS = 1'b1;
`else
  localparam logic EXP_MIS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  serial_compare_feeder_msb_first_if #(.W(W)) bus8 ();
  serial_compare_feeder_msb_first_if #(.W(1)) bus1 ();

  serial_compare_feeder_msb_first #(.W(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_compare_feeder_msb_first #(.W(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial comparator model: first differing bit decides, restarted by
  // ser_clear; verdict visible combinationally during the current bit.
  logic c8_dec, c8_lt;
  always_ff @(posedge clk) begin
    if (rst || bus8.ser_clear) begin
      c8_dec <= 1'b0;
      c8_lt  <= 1'b0;
    end else if (bus8.ser_valid && !c8_dec && (bus8.ser_a != bus8.ser_b)) begin
      c8_dec <= 1'b1;
      c8_lt  <= bus8.ser_b;
    end
  end

  always_comb begin
    bus8.cmp_less    = 1'b0;
    bus8.cmp_eq      = 1'b1;
    bus8.cmp_greater = 1'b0;
    if (c8_dec) begin
      bus8.cmp_less    = c8_lt;
      bus8.cmp_eq      = 1'b0;
      bus8.cmp_greater = !c8_lt;
    end else if (bus8.ser_valid && (bus8.ser_a != bus8.ser_b)) begin
      bus8.cmp_less    = bus8.ser_b;
      bus8.cmp_eq      = 1'b0;
      bus8.cmp_greater = bus8.ser_a;
    end
  end

  // Faulty comparator for the W=1 instance: always reports less.
  assign bus1.cmp_less    = 1'b1;
  assign bus1.cmp_eq      = 1'b0;
  assign bus1.cmp_greater = 1'b0;

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a < b, a == b, a > b};
  endfunction

  task automatic test_reset();
    logic [10:0] o8, o1;
    bus8.in_valid = 0; bus8.in_a = '0; bus8.in_b = '0; bus8.res_ready = 1;
    bus1.in_valid = 0; bus1.in_a = '0; bus1.in_b = '0; bus1.res_ready = 1;
    rst = 1;
    repeat (3) @(negedge clk);
    o8 = {bus8.ser_clear, bus8.ser_valid, bus8.ser_last, bus8.ser_a, bus8.ser_b, bus8.in_ready,
          bus8.res_valid, bus8.res_less, bus8.res_eq, bus8.res_greater, bus8.res_mismatch};
    o1 = {bus1.ser_clear, bus1.ser_valid, bus1.ser_last, bus1.ser_a, bus1.ser_b, bus1.in_ready,
          bus1.res_valid, bus1.res_less, bus1.res_eq, bus1.res_greater, bus1.res_mismatch};
    n_vec++;
    if (o8 !== 11'b0) begin n_err++; $display("FAIL reset_outputs_w8 got %b want %b", o8, 11'b0); end
    n_vec++;
    if (o1 !== 11'b0) begin n_err++; $display("FAIL reset_outputs_w1 got %b want %b", o1, 11'b0); end
    rst = 0;
    @(negedge clk);
    n_vec++;
    if ({bus8.in_ready, bus1.in_ready} !== 2'b11) begin
      n_err++; $display("FAIL reset_in_ready got %b want 11", {bus8.in_ready, bus1.in_ready});
    end
  endtask

  // Starts and ends at a negedge with the W=8 feeder idle. Checks every
  // cycle of the transaction; hold > 0 stalls res_ready and pokes junk on
  // the input side, which must be ignored.
  task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [6:0] o, e;
    logic [2:0] r;
    r = ref_cmp(a, b);
    n_vec++;
    if (bus8.in_ready !== 1'b1) begin n_err++; $display("FAIL word_start_ready got %b want 1", bus8.in_ready); end
    bus8.in_a = a; bus8.in_b = b; bus8.in_valid = 1; bus8.res_ready = (hold == 0);
    @(negedge clk);
    bus8.in_valid = (hold > 0);
    bus8.in_a = W'($urandom); bus8.in_b = W'($urandom);
    o = {bus8.ser_clear, bus8.ser_valid, bus8.ser_last, 2'b00, bus8.in_ready, bus8.res_valid};
    n_vec++;
    if (o !== 7'b1000000) begin n_err++; $display("FAIL clear_cycle got %b want %b", o, 7'b1000000); end
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      bus8.in_a = W'($urandom); bus8.in_b = W'($urandom);
      o = {bus8.ser_clear, bus8.ser_valid, bus8.ser_last, bus8.ser_a, bus8.ser_b, bus8.in_ready, bus8.res_valid};
      e = {1'b0, 1'b1, (i == W - 1), a[W-1-i], b[W-1-i], 1'b0, 1'b0};
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL shift_bit%0d a=%h b=%h got %b want %b", i, a, b, o, e); end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      o = {bus8.ser_valid, bus8.in_ready, bus8.res_valid, bus8.res_less, bus8.res_eq, bus8.res_greater, bus8.res_mismatch};
      e = {1'b0, 1'b0, 1'b1, r, 1'b0};
      n_vec++;
      if (o !== e) begin n_err++; $display("FAIL result a=%h b=%h hold%0d got %b want %b", a, b, h, o, e); end
      if (h == hold) begin bus8.res_ready = 1; bus8.in_valid = 0; end
    end
    @(negedge clk);
    bus8.in_valid = 0;
    o = {3'b000, bus8.in_ready, bus8.res_valid, bus8.ser_valid, bus8.ser_clear};
    n_vec++;
    if (o !== 7'b0001000) begin n_err++; $display("FAIL back_to_idle got %b want %b", o, 7'b0001000); end
  endtask

  task automatic test_patterns();
    run_word(8'hA5, 8'hA5, 0);
    run_word(8'h80, 8'h7F, 0);
    run_word(8'h00, 8'hFF, 5);
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int k = 0; k < 10; k++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
      run_word(a, b, $urandom_range(0, 3));
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] pa [3];
    logic [W-1:0] pb [3];
    int acc [$];
    int k = 0, nres = 0;
    logic upd = 0, prev_clear = 0, prev_valid = 0;
    logic [2:0] o, e;
    pa = '{8'h3C, 8'hF0, 8'h55}; pb = '{8'h3D, 8'h0F, 8'h55};
    bus8.res_ready = 1; bus8.in_valid = 1; bus8.in_a = pa[0]; bus8.in_b = pb[0];
    for (int c = 0; c < 100 && nres < 3; c++) begin
      if (bus8.in_ready && bus8.in_valid) begin acc.push_back(cyc); k++; upd = 1; end
      @(negedge clk);
      if (upd) begin
        if (k < 3) begin bus8.in_a = pa[k]; bus8.in_b = pb[k]; end
        else bus8.in_valid = 0;
        upd = 0;
      end
      if (bus8.ser_valid && !prev_valid) begin
        n_vec++;
        if (prev_clear !== 1'b1) begin n_err++; $display("FAIL b2b_clear_before_bit got %b want 1", prev_clear); end
      end
      if (bus8.res_valid) begin
        o = {bus8.res_less, bus8.res_eq, bus8.res_greater};
        e = ref_cmp(pa[nres], pb[nres]);
        n_vec++;
        if (o !== e) begin n_err++; $display("FAIL b2b_result%0d got %b want %b", nres, o, e); end
        nres++;
      end
      prev_clear = bus8.ser_clear; prev_valid = bus8.ser_valid;
    end
    n_vec++;
    if (nres != 3 || acc.size() != 3) begin
      n_err++; $display("FAIL b2b_count results %0d accepts %0d want 3 3", nres, acc.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        n_vec++;
        if (acc[i] - acc[i-1] != W + 3) begin
          n_err++; $display("FAIL b2b_spacing%0d got %0d want %0d", i, acc[i] - acc[i-1], W + 3);
        end
      end
    end
    bus8.in_valid = 0;
    @(negedge clk);
  endtask

  task automatic test_rst_mid();
    logic [10:0] o;
    bus8.in_a = 8'h12; bus8.in_b = 8'h34; bus8.in_valid = 1; bus8.res_ready = 1;
    @(negedge clk);
    bus8.in_valid = 0;
    repeat (4) @(negedge clk);
    rst = 1;
    @(negedge clk);
    o = {bus8.ser_clear, bus8.ser_valid, bus8.ser_last, bus8.ser_a, bus8.ser_b, bus8.in_ready,
         bus8.res_valid, bus8.res_less, bus8.res_eq, bus8.res_greater, bus8.res_mismatch};
    n_vec++;
    if (o !== 11'b0) begin n_err++; $display("FAIL rst_mid_outputs got %b want %b", o, 11'b0); end
    rst = 0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      n_vec++;
      if ({bus8.in_ready, bus8.res_valid, bus8.ser_valid} !== 3'b100) begin
        n_err++; $display("FAIL rst_mid_idle%0d got %b want 100", i, {bus8.in_ready, bus8.res_valid, bus8.ser_valid});
      end
    end
    run_word(8'hC3, 8'h3C, 0);
    run_word(8'h12, 8'h34, 1);
  endtask

  task automatic test_w1_selfcheck();
    logic [4:0] o;
    bus1.res_ready = 1; bus1.in_a = 1'b1; bus1.in_b = 1'b0; bus1.in_valid = 1;
    @(negedge clk);
    bus1.in_valid = 0;
    o = {bus1.ser_clear, bus1.ser_valid, bus1.ser_last, bus1.in_ready, bus1.res_valid};
    n_vec++;
    if (o !== 5'b10000) begin n_err++; $display("FAIL w1_clear got %b want 10000", o); end
    @(negedge clk);
    o = {bus1.ser_valid, bus1.ser_last, bus1.ser_a, bus1.ser_b, bus1.res_valid};
    n_vec++;
    if (o !== 5'b11100) begin n_err++; $display("FAIL w1_bit got %b want 11100", o); end
    @(negedge clk);
    o = {bus1.res_valid, bus1.res_less, bus1.res_eq, bus1.res_greater, bus1.res_mismatch};
    n_vec++;
    if (o !== {4'b1100, EXP_MIS}) begin n_err++; $display("FAIL w1_result got %b want %b", o, {4'b1100, EXP_MIS}); end
    @(negedge clk);
    o = {bus1.res_valid, bus1.in_ready, bus1.res_mismatch, bus1.ser_valid, bus1.ser_clear};
    n_vec++;
    if (o !== 5'b01000) begin n_err++; $display("FAIL w1_idle got %b want 01000", o); end
  endtask

  initial begin
    test_reset();
    test_patterns();
    test_random();
    test_back_to_back();
    test_rst_mid();
    test_w1_selfcheck();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got %0d cycles want completion", cyc);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/serial_compare_feeder_msb_first.md
# serial_compare_feeder_msb_first

Front-end controller for the MSB-first serial comparator. It accepts a pair of W-bit parallel words over a valid/ready handshake, clears the comparator, and shifts both words out one bit per cycle, most significant bit first. It captures the comparator's verdict on the final bit and presents it downstream with its own valid/ready handshake. It sits between the parallel datapath and the serial comparator stage.

## Interface
- W, 8, word width in bits; legal range W ≥ 1.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  parallel word pair valid.
- in_ready  output  1  feeder can accept a word pair.
- in_a  input  W  operand A.
- in_b  input  W  operand B.
- ser_clear  output  1  one-cycle restart pulse; OR-ed into the comparator's rst.
- ser_a  output  1  serial bit of A, MSB first.
- ser_b  output  1  serial bit of B, MSB first.
- ser_valid  output  1  ser_a/ser_b carry a live bit.
- ser_last  output  1  current bit is the LSB.
- cmp_less  input  1  comparator a_less_b.
- cmp_eq  input  1  comparator a_eq_b.
- cmp_greater  input  1  comparator a_greater_b.
- res_valid  output  1  captured result available.
- res_ready  input  1  consumer takes the result.
- res_less, res_eq, res_greater  output  1 each  captured verdict; exactly one is high when res_valid = 1.
- res_mismatch  output  1  self-check failure flag (see Configuration).

## Operation
- FSM states: IDLE, CLEAR, SHIFT, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready, latch in_a/in_b into shift registers and go to CLEAR.
- CLEAR: ser_clear = 1 for exactly one cycle, ser_valid = 0. Load bit counter with W-1. Go to SHIFT.
- SHIFT: ser_valid = 1; ser_a/ser_b = register MSBs. Shift left each cycle and decrement the counter. ser_last = 1 when counter = 0. On the ser_last cycle, capture cmp_less/cmp_eq/cmp_greater into res_* and go to DONE.
- DONE: res_valid = 1; res_* held stable. On res_ready, go to IDLE. in_ready = 0 until IDLE is re-entered.
- in_valid in any state other than IDLE is ignored and does not overwrite the operands.
- W = 1: SHIFT lasts one cycle, and ser_last is asserted in that cycle.
- Counter width is max(1, $clog2(W)).

## Timing
- Reset values: state IDLE; ser_clear, ser_a, ser_b, ser_valid, ser_last, res_valid, res_less, res_eq, res_greater, res_mismatch all 0. in_ready is 0 while rst is high and 1 in the first cycle after rst deasserts.
- Accept at edge T. ser_clear is high in cycle T+1. Bits occupy cycles T+2 … T+W+1. res_valid rises in cycle T+W+2.
- Minimum period per word: W+3 cycles (res_ready tied high).
- ser_a/ser_b/ser_valid/ser_last/ser_clear are registered outputs. in_ready and res_valid decode directly from state.
- rst mid-operation (any state): return to IDLE next edge. The pending word and any result are discarded, and no res_valid is produced.

## Configuration
- SERCMP_FEEDER_SELFCHECK_EN defined: on accept, also register the parallel comparison in_a < in_b / == / >. On capture, res_mismatch = 1 if the serial verdict differs, or if the number of high cmp_* bits is not exactly one. res_mismatch is held with res_valid and cleared on leaving DONE.
- Not defined: res_mismatch is tied to 0 and no parallel comparator is synthesized.

## Structure
- Package sercmp_pkg: state enum (IDLE, CLEAR, SHIFT, DONE) and a packed result struct {less, eq, greater}.
- One sub-module: sercmp_piso (parallel-in serial-out, W-bit, load/shift enable, MSB output), instantiated twice, once for A and once for B.
- FSM, counter, and result capture live in the top module.

## Test plan
- W=8, in_a=8'hA5, in_b=8'hA5, res_ready=1 → ser_a bits 1,0,1,0,0,1,0,1. res_eq=1 at T+10, res_valid high for one cycle.
- W=8, in_a=8'h80, in_b=8'h7F → res_greater=1. Confirms MSB-first ordering; an LSB-first bug would give res_less.
- W=8, in_a=8'h00, in_b=8'hFF, res_ready=0 for 5 cycles → res_valid and res_less held stable. in_ready stays 0 and a new in_valid is ignored until the handshake completes.
- Back-to-back: three pairs with in_valid always high → accepts spaced exactly W+3 cycles apart, and ser_clear precedes each first bit by one cycle.
- rst asserted during the 4th SHIFT cycle → next cycle IDLE, all outputs at reset values, no res_valid. The following word compares correctly.
- W=1 with SERCMP_FEEDER_SELFCHECK_EN: in_a=1, in_b=0, comparator model forced to report less → res_mismatch=1 with res_valid. With the macro undefined, res_mismatch=0.
